// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: decides at each instruction boundary whether to take
// res/nmi/irq (or run a BRK), then steps the seven-cycle push/vector sequence,
// drives the vector address and write suppression, and returns handled pulses.
module interrupt_sequencer #(
    parameter logic [15:0] NMI_VEC = 16'hFFFA,
    parameter logic [15:0] RES_VEC = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
    input  logic        phi1,
    input  logic        rstAll,
    input  logic        sync,
    input  logic        nmi,
    input  logic        irq,
    input  logic        res,
    input  logic        iFlag,
    input  logic        brk,
    input  logic        RDY,
    output logic        interrupt,
    output logic        seqActive,
    output logic [2:0]  tState,
    output logic        suppressWrite,
    output logic        pushB,
    output logic        setI,
    output logic [15:0] vecAddr,
    output logic        vecFetch,
    output logic        nmiHandled,
    output logic        irqHandled,
    output logic        resHandled
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_T6   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_BRK  = 3'd1,
        SRC_IRQ  = 3'd2,
        SRC_NMI  = 3'd3,
        SRC_RES  = 3'd4
    } src_t;

    state_t      r_state;
    state_t      w_nState;
    src_t        r_src;
    src_t        w_nSrc;
    logic        r_isBrk;
    logic        w_nIsBrk;
    logic        r_nmiPrev;
    logic        w_nmiRise;
    logic        w_pushPhase;
    logic        w_stall;
    logic        w_exit;
    logic [15:0] w_vecBase;

    logic        r_interrupt;
    logic        r_seqActive;
    logic        r_suppressWrite;
    logic        r_pushB;
    logic        r_setI;
    logic [15:0] r_vecAddr;
    logic        r_vecFetch;
    logic        r_nmiHandled;
    logic        r_irqHandled;
    logic        r_resHandled;

    // Next state and source: take decision in IDLE, reset abandon, NMI hijack, stepping with stalls.
    always_comb begin
        w_nmiRise   = nmi & ~r_nmiPrev;
        w_pushPhase = (r_state == ST_T2) || (r_state == ST_T3) || (r_state == ST_T4);
        // Pushes are real writes unless the sequence is a reset, so only reads stall on RDY.
        w_stall     = ~RDY & ((r_state == ST_T1) || (r_state == ST_T5) || (r_state == ST_T6) ||
                              (w_pushPhase && (r_src == SRC_RES)));
        w_nState    = r_state;
        w_nSrc      = r_src;
        w_nIsBrk    = r_isBrk;
        w_exit      = 1'b0;
        if (r_state == ST_IDLE) begin
            if (sync && res) begin
                w_nSrc   = SRC_RES;
                w_nState = ST_T1;
                w_nIsBrk = 1'b0;
            end else if (sync && nmi) begin
                w_nSrc   = SRC_NMI;
                w_nState = ST_T1;
                w_nIsBrk = 1'b0;
            end else if (sync && irq && !iFlag) begin
                w_nSrc   = SRC_IRQ;
                w_nState = ST_T1;
                w_nIsBrk = 1'b0;
            end else if (brk) begin
                w_nSrc   = SRC_BRK;
                w_nState = ST_T1;
                w_nIsBrk = 1'b1;
            end
        end else if (res && (r_src != SRC_RES)) begin
            // Reset abandons any other sequence outright; the partial one never reports.
            w_nSrc   = SRC_RES;
            w_nState = ST_T1;
            w_nIsBrk = 1'b0;
        end else begin
            // The BRK flag is kept separately so a hijacked BRK still pushes B=1.
            if (w_nmiRise && ((r_src == SRC_IRQ) || (r_src == SRC_BRK)) &&
                (r_state != ST_T5) && (r_state != ST_T6)) begin
                w_nSrc = SRC_NMI;
            end
            if (!w_stall) begin
                if (r_state == ST_T6) begin
                    w_nState = ST_IDLE;
                    w_nSrc   = SRC_NONE;
                    w_nIsBrk = 1'b0;
                    w_exit   = 1'b1;
                end else begin
                    w_nState = state_t'(r_state + 3'd1);
                end
            end
        end
    end

    // Vector low-byte address selected by the source that will own the next state.
    always_comb begin
        case (w_nSrc)
            SRC_NMI:          w_vecBase = NMI_VEC;
            SRC_IRQ, SRC_BRK: w_vecBase = IRQ_VEC;
            default:          w_vecBase = RES_VEC;
        endcase
    end

    // State, source and all registered outputs, derived from the next state.
    always_ff @(posedge phi1 or posedge rstAll) begin
        if (rstAll) begin
            r_state         <= ST_IDLE;
            r_src           <= SRC_NONE;
            r_isBrk         <= 1'b0;
            r_nmiPrev       <= 1'b0;
            r_interrupt     <= 1'b0;
            r_seqActive     <= 1'b0;
            r_suppressWrite <= 1'b0;
            r_pushB         <= 1'b0;
            r_setI          <= 1'b0;
            r_vecAddr       <= RES_VEC;
            r_vecFetch      <= 1'b0;
            r_nmiHandled    <= 1'b0;
            r_irqHandled    <= 1'b0;
            r_resHandled    <= 1'b0;
        end else begin
            r_state         <= w_nState;
            r_src           <= w_nSrc;
            r_isBrk         <= w_nIsBrk;
            r_nmiPrev       <= nmi;
            r_interrupt     <= (w_nState == ST_T1) && !w_nIsBrk;
            r_seqActive     <= (w_nState != ST_IDLE);
            r_suppressWrite <= ((w_nState == ST_T2) || (w_nState == ST_T3) || (w_nState == ST_T4)) &&
                               (w_nSrc == SRC_RES);
            r_pushB         <= (w_nState == ST_T4) && w_nIsBrk;
            r_setI          <= (w_nState == ST_T5);
            r_vecAddr       <= w_vecBase + {15'd0, (w_nState == ST_T6)};
            r_vecFetch      <= (w_nState == ST_T5) || (w_nState == ST_T6);
            r_nmiHandled    <= w_exit && (r_src == SRC_NMI);
            r_irqHandled    <= w_exit && (r_src == SRC_IRQ);
            r_resHandled    <= w_exit && (r_src == SRC_RES);
        end
    end

    assign tState        = r_state;
    assign interrupt     = r_interrupt;
    assign seqActive     = r_seqActive;
    assign suppressWrite = r_suppressWrite;
    assign pushB         = r_pushB;
    assign setI          = r_setI;
    assign vecAddr       = r_vecAddr;
    assign vecFetch      = r_vecFetch;
    assign nmiHandled    = r_nmiHandled;
    assign irqHandled    = r_irqHandled;
    assign resHandled    = r_resHandled;

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Consumes the prioritised nmi/irq/res levels from the interrupt/reset control stage and the BRK decode.
- At each instruction boundary, decides whether to take an interrupt. If so, it asserts interrupt so predecode forces opcode 00.
- Then steps the seven-cycle push/vector sequence, drives vector address and stack-write suppression, and returns one-cycle handled pulses to the interrupt/reset control stage.
- Sits between interrupt/reset control and the random-control/timing logic.

Parameters:
NMI_VEC, 16'hFFFA, NMI vector low-byte address
RES_VEC, 16'hFFFC, reset vector low-byte address
IRQ_VEC, 16'hFFFE, IRQ/BRK vector low-byte address

Ports:
phi1  in  1  sequencer clock, rising edge active
rstAll  in  1  reset, asynchronous, active-high
sync  in  1  opcode-fetch cycle (instruction boundary)
nmi  in  1  NMI pending (level)
irq  in  1  IRQ pending (level)
res  in  1  reset pending (level)
iFlag  in  1  processor I flag; 1 masks irq
brk  in  1  BRK opcode decoded (valid in T1)
RDY  in  1  ready; 0 stalls read cycles
interrupt  out  1  to predecode: force opcode 00
seqActive  out  1  sequence in progress (T1..T6)
tState  out  3  0=IDLE, 1..6=T1..T6
suppressWrite  out  1  force read during push cycles (reset only)
pushB  out  1  B bit for pushed P: 1 for BRK, 0 otherwise
setI  out  1  set I flag (one cycle, T5)
vecAddr  out  16  vector address to address bus
vecFetch  out  1  vecAddr valid (T5 low byte, T6 high byte)
nmiHandled  out  1  one-cycle pulse
irqHandled  out  1  one-cycle pulse
resHandled  out  1  one-cycle pulse

Behaviour:
- Reset (async, rstAll=1): tState=IDLE; all 1-bit outputs 0; vecAddr=RES_VEC; internal source register cleared. After release, a pending res is taken at the next sync.
- Source register src (NONE/BRK/IRQ/NMI/RES) is internal.
- Take decision, on a phi1 edge with sync=1 in IDLE:
  - res -> RES; else nmi -> NMI; else irq&~iFlag -> IRQ.
  - If any source is taken: interrupt=1 from that edge until the edge entering T2; tState->T1.
- BRK: in IDLE with brk=1 and no source taken, src=BRK, tState->T1. interrupt stays 0 and pushB=1.
- Step sequence: T1 dummy read -> T2 push PCH -> T3 push PCL -> T4 push P -> T5 vector low -> T6 vector high -> IDLE. One state per phi1 edge.
- Stall: with RDY=0, the state holds during T1, T5, T6, and during T2-T4 when src=RES. Non-reset T2-T4 are writes and ignore RDY.
- suppressWrite=1 in T2-T4 iff src=RES; 0 otherwise.
- pushB=1 in T4 iff src=BRK; 0 otherwise.
- vecAddr:
  - T5: NMI_VEC/RES_VEC/IRQ_VEC by src; BRK uses IRQ_VEC.
  - T6: same value +1.
  - vecFetch=1 in T5 and T6 only.
- setI=1 during T5 only.
- NMI hijack: nmi rising while src is IRQ or BRK, sampled at any edge in T1..T4, changes src to NMI.
  - Vector becomes NMI_VEC.
  - pushB keeps the original BRK value.
  - Hijack from T5 onward is ignored; that nmi is taken at the next sync.
- Handled pulse: exactly one cycle on the edge leaving T6, for the final src (nmiHandled for a hijacked IRQ). BRK produces no pulse.
- res during a non-RES sequence: abandon immediately at the next edge. src=RES, tState->T1, interrupt=1; the partial sequence produces no pulse.
- sync and pending lines are ignored while seqActive=1, except res and the hijack rule.
- Simultaneous nmi+irq: NMI wins; irq stays pending and is re-evaluated at the next sync after the handler's first opcode.
- Masked irq (iFlag=1): no action and no pulse; irq stays pending.
- rstAll mid-sequence: immediate return to the reset state. No handled pulse.

Test Plan:
- Reset release with res=1, sync=1 -> T1..T6 in 7 edges; suppressWrite=1 T2-T4; vecAddr FFFC then FFFD; resHandled pulses once; tState=0.
- irq=1, iFlag=0 at sync -> interrupt=1 at T1; pushB=0 at T4; vecAddr FFFE/FFFF; setI in T5; irqHandled 1 cycle.
- irq=1, iFlag=1 at sync -> stays IDLE, interrupt=0, no pulses.
- brk=1 in IDLE -> interrupt=0; pushB=1 at T4; vecAddr FFFE; no handled pulse.
- IRQ sequence, nmi asserted in T3 -> vecAddr FFFA/FFFB; nmiHandled pulses; irqHandled does not.
- RDY=0 for 3 cycles during T5 -> tState holds 5, vecAddr holds FFFE; total sequence 10 edges. res asserted in T3 of IRQ -> restarts T1 with src=RES, vector FFFC.
